// File: rtl/i2c_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : i2c_peripheral
// Description : Single-address I2C target. Oversamples scl/sda, detects
//               START/STOP, matches a 7-bit address, ACKs, delivers received
//               bytes and shifts out fabric-supplied bytes. Never drives scl.
//               Optional macro I2C_PERIPH_GLITCH_FILTER_EN adds a
//               3-sample majority-free glitch filter on both lines.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_peripheral #(
    parameter logic [6:0] ADDR = 7'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx_byte,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       tx_req,
    output logic       busy,
    output logic [3:0] state
);

    localparam logic [3:0] c_st_idle     = 4'd0;
    localparam logic [3:0] c_st_addr     = 4'd1;
    localparam logic [3:0] c_st_addr_ack = 4'd2;
    localparam logic [3:0] c_st_rx       = 4'd3;
    localparam logic [3:0] c_st_rx_ack   = 4'd4;
    localparam logic [3:0] c_st_tx       = 4'd5;
    localparam logic [3:0] c_st_tx_ack   = 4'd6;
    localparam logic [3:0] c_st_ignore   = 4'd7;

    logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic       r_scl_prev, r_sda_prev;
    logic       w_scl_c, w_sda_c;
    logic       r_scl_rise, r_scl_fall, r_start, r_stop;

    logic [3:0] r_state, w_state_nx;
    logic [2:0] r_bit_cnt, w_cnt_nx;
    logic       r_full, w_full_nx;
    logic [7:0] r_shift, w_shift_nx;
    logic       r_sda_low, w_drive_nx;
    logic       r_rw, w_rw_nx;
    logic       r_nack, w_nack_nx;
    logic       r_busy, w_busy_nx;
    logic [7:0] r_rx_byte, w_rx_byte_nx;
    logic       w_rx_valid, w_tx_req;

    // Two-flop synchronizers; idle bus level is high, so reset to 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            r_scl_s1 <= scl;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= sda;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef I2C_PERIPH_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist, r_sda_hist;

    // Sample history: a new level is accepted only after 3 identical samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_s2};
            r_sda_hist <= {r_sda_hist[0], r_sda_s2};
        end
    end

    assign w_scl_c = (r_scl_hist == {2{r_scl_s2}}) ? r_scl_s2 : r_scl_prev;
    assign w_sda_c = (r_sda_hist == {2{r_sda_s2}}) ? r_sda_s2 : r_sda_prev;
`else
    assign w_scl_c = r_scl_s2;
    assign w_sda_c = r_sda_s2;
`endif

    // Registered bus-event detection: scl edges and START/STOP conditions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
            r_scl_rise <= 1'b0;
            r_scl_fall <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
        end else begin
            r_scl_prev <= w_scl_c;
            r_sda_prev <= w_sda_c;
            r_scl_rise <= w_scl_c & ~r_scl_prev;
            r_scl_fall <= ~w_scl_c & r_scl_prev;
            r_start    <= w_scl_c & r_scl_prev & r_sda_prev & ~w_sda_c;
            r_stop     <= w_scl_c & r_scl_prev & ~r_sda_prev & w_sda_c;
        end
    end

    // FSM state and datapath registers; reset releases the bus at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= 3'd0;
            r_full    <= 1'b0;
            r_shift   <= 8'h00;
            r_sda_low <= 1'b0;
            r_rw      <= 1'b0;
            r_nack    <= 1'b0;
            r_busy    <= 1'b0;
            r_rx_byte <= 8'h00;
        end else begin
            r_state   <= w_state_nx;
            r_bit_cnt <= w_cnt_nx;
            r_full    <= w_full_nx;
            r_shift   <= w_shift_nx;
            r_sda_low <= w_drive_nx;
            r_rw      <= w_rw_nx;
            r_nack    <= w_nack_nx;
            r_busy    <= w_busy_nx;
            r_rx_byte <= w_rx_byte_nx;
        end
    end

    // Next-state and pulse decode; START/STOP override any data/ACK action.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_bit_cnt;
        w_full_nx    = r_full;
        w_shift_nx   = r_shift;
        w_drive_nx   = r_sda_low;
        w_rw_nx      = r_rw;
        w_nack_nx    = r_nack;
        w_busy_nx    = r_busy;
        w_rx_byte_nx = r_rx_byte;
        w_rx_valid   = 1'b0;
        w_tx_req     = 1'b0;
        if (r_start || r_stop) begin
            w_state_nx = r_start ? c_st_addr : c_st_idle;
            w_cnt_nx   = 3'd0;
            w_full_nx  = 1'b0;
            w_drive_nx = 1'b0;
            w_busy_nx  = 1'b0;
        end else begin
            case (r_state)
                c_st_addr, c_st_rx: begin
                    if (r_scl_rise) begin
                        w_shift_nx = {r_shift[6:0], r_sda_prev};
                        w_cnt_nx   = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) w_full_nx = 1'b1;
                    end else if (r_scl_fall && r_full) begin
                        w_full_nx = 1'b0;
                        if (r_state == c_st_addr) begin
                            if (r_shift[7:1] == ADDR) begin
                                w_state_nx = c_st_addr_ack;
                                w_drive_nx = 1'b1;
                                w_busy_nx  = 1'b1;
                                w_rw_nx    = r_shift[0];
                            end else begin
                                w_state_nx = c_st_ignore;
                            end
                        end else begin
                            w_rx_valid   = 1'b1;
                            w_rx_byte_nx = r_shift;
                            w_state_nx   = c_st_rx_ack;
                            w_drive_nx   = 1'b1;
                        end
                    end
                end
                c_st_addr_ack: begin
                    if (r_scl_fall) begin
                        w_cnt_nx = 3'd0;
                        if (r_rw) begin
                            w_tx_req   = 1'b1;
                            w_shift_nx = tx_byte;
                            w_drive_nx = ~tx_byte[7];
                            w_state_nx = c_st_tx;
                        end else begin
                            w_drive_nx = 1'b0;
                            w_state_nx = c_st_rx;
                        end
                    end
                end
                c_st_rx_ack: begin
                    if (r_scl_fall) begin
                        w_drive_nx = 1'b0;
                        w_cnt_nx   = 3'd0;
                        w_state_nx = c_st_rx;
                    end
                end
                c_st_tx: begin
                    if (r_scl_rise) begin
                        w_cnt_nx = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) w_full_nx = 1'b1;
                    end else if (r_scl_fall) begin
                        if (r_full) begin
                            w_full_nx  = 1'b0;
                            w_drive_nx = 1'b0;
                            w_state_nx = c_st_tx_ack;
                        end else begin
                            w_shift_nx = {r_shift[6:0], 1'b0};
                            w_drive_nx = ~r_shift[6];
                        end
                    end
                end
                c_st_tx_ack: begin
                    if (r_scl_rise) begin
                        w_nack_nx = r_sda_prev;
                    end else if (r_scl_fall) begin
                        w_cnt_nx = 3'd0;
                        if (!r_nack) begin
                            w_tx_req   = 1'b1;
                            w_shift_nx = tx_byte;
                            w_drive_nx = ~tx_byte[7];
                            w_state_nx = c_st_tx;
                        end else begin
                            w_state_nx = c_st_ignore;
                        end
                    end
                end
                default: begin
                    w_drive_nx = 1'b0;
                end
            endcase
        end
    end

    assign sda      = r_sda_low ? 1'b0 : 1'bz;
    assign rx_valid = w_rx_valid;
    assign tx_req   = w_tx_req;
    assign rx_byte  = w_rx_valid ? r_shift : r_rx_byte;
    assign busy     = r_busy;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_i2c_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_peripheral
// Description : Directed self-checking bench for i2c_peripheral, acting as
//               the bus controller with an open-drain sda model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_peripheral;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       tb_sda_low;
    wire        sda;
    logic [7:0] tx_byte;
    logic [7:0] rx_byte;
    logic       rx_valid, tx_req, busy;
    logic [3:0] state;

    int         vec_cnt = 0;
    int         err_cnt = 0;
    int         rxv_cnt = 0;
    int         txr_cnt = 0;
    int         both_cnt = 0;
    int         dut_low_cnt = 0;
    int         busy_seen = 0;
    logic [7:0] rx_last = 8'h00;

    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_peripheral #(.ADDR(7'd5)) dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .tx_byte  (tx_byte),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .tx_req   (tx_req),
        .busy     (busy),
        .state    (state)
    );

    // Observe pulses and bus activity away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            rxv_cnt = rxv_cnt + 1;
            rx_last = rx_byte;
        end
        if (tx_req) txr_cnt = txr_cnt + 1;
        if (rx_valid && tx_req) both_cnt = both_cnt + 1;
        if (!tb_sda_low && sda == 1'b0) dut_low_cnt = dut_low_cnt + 1;
        if (busy) busy_seen = busy_seen + 1;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        tb_sda_low = 1'b0;
        scl = 1'b1;
        wait_clk(Q);
        tb_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_rstart();
        tb_sda_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        tb_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        tb_sda_low = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        tb_sda_low = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        tb_sda_low = ~b;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(2 * Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        tb_sda_low = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        b = (sda !== 1'b0);
        wait_clk(Q);
        scl = 1'b0;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        scl = 1'b1;
        tb_sda_low = 1'b0;
        tx_byte = 8'h00;
        wait_clk(3);
        vec_cnt++; if (state !== 4'd0) begin err_cnt++; $display("FAIL reset_state: got %0d want 0", state); end
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
        vec_cnt++; if (rx_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        vec_cnt++; if (tx_req !== 1'b0) begin err_cnt++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
        vec_cnt++; if (rx_byte !== 8'h00) begin err_cnt++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
        vec_cnt++; if (sda !== 1'b1) begin err_cnt++; $display("FAIL reset_sda: got %b want released", sda); end
        reset = 1'b0;
        wait_clk(Q);
    endtask

    task automatic test_write();
        logic ack;
        rxv_cnt = 0;
        bus_start();
        write_byte({7'd5, 1'b0}, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL write_addr_ack: got %b want 0", ack); end
        write_byte(8'h07, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL write_data_ack: got %b want 0", ack); end
        vec_cnt++; if (rxv_cnt !== 1) begin err_cnt++; $display("FAIL write_rx_valid_cnt: got %0d want 1", rxv_cnt); end
        vec_cnt++; if (rx_last !== 8'h07) begin err_cnt++; $display("FAIL write_rx_byte: got %h want 07", rx_last); end
        vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL write_busy_mid: got %b want 1", busy); end
        bus_stop();
        vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL write_busy_stop: got %b want 0", busy); end
        vec_cnt++; if (state !== 4'd0) begin err_cnt++; $display("FAIL write_state_stop: got %0d want 0", state); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] d;
        txr_cnt = 0;
        tx_byte = 8'hA5;
        bus_start();
        write_byte({7'd5, 1'b1}, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL read_addr_ack: got %b want 0", ack); end
        read_byte(1'b1, d);
        vec_cnt++; if (d !== 8'hA5) begin err_cnt++; $display("FAIL read_data: got %h want a5", d); end
        vec_cnt++; if (txr_cnt !== 1) begin err_cnt++; $display("FAIL read_tx_req_cnt: got %0d want 1", txr_cnt); end
        vec_cnt++; if (state !== 4'd7) begin err_cnt++; $display("FAIL read_state_nack: got %0d want 7", state); end
        bus_stop();
        vec_cnt++; if (state !== 4'd0) begin err_cnt++; $display("FAIL read_state_stop: got %0d want 0", state); end
    endtask

    task automatic test_mismatch();
        logic ack;
        rxv_cnt = 0;
        dut_low_cnt = 0;
        busy_seen = 0;
        bus_start();
        write_byte({7'd6, 1'b0}, ack);
        vec_cnt++; if (ack !== 1'b1) begin err_cnt++; $display("FAIL mismatch_addr_ack: got %b want 1", ack); end
        write_byte(8'hFF, ack);
        vec_cnt++; if (ack !== 1'b1) begin err_cnt++; $display("FAIL mismatch_data_ack: got %b want 1", ack); end
        vec_cnt++; if (state !== 4'd7) begin err_cnt++; $display("FAIL mismatch_state: got %0d want 7", state); end
        bus_stop();
        vec_cnt++; if (dut_low_cnt !== 0) begin err_cnt++; $display("FAIL mismatch_sda_driven: got %0d want 0", dut_low_cnt); end
        vec_cnt++; if (rxv_cnt !== 0) begin err_cnt++; $display("FAIL mismatch_rx_valid: got %0d want 0", rxv_cnt); end
        vec_cnt++; if (busy_seen !== 0) begin err_cnt++; $display("FAIL mismatch_busy: got %0d want 0", busy_seen); end
    endtask

    task automatic test_repeated_start();
        logic       ack;
        logic [7:0] d;
        rxv_cnt = 0;
        txr_cnt = 0;
        tx_byte = 8'h3C;
        bus_start();
        write_byte({7'd5, 1'b0}, ack);
        write_byte(8'h10, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rstart_data_ack: got %b want 0", ack); end
        bus_rstart();
        vec_cnt++; if (state !== 4'd1) begin err_cnt++; $display("FAIL rstart_state: got %0d want 1", state); end
        write_byte({7'd5, 1'b1}, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL rstart_addr_ack: got %b want 0", ack); end
        read_byte(1'b0, d);
        vec_cnt++; if (d !== 8'h3C) begin err_cnt++; $display("FAIL rstart_byte0: got %h want 3c", d); end
        read_byte(1'b1, d);
        vec_cnt++; if (d !== 8'h3C) begin err_cnt++; $display("FAIL rstart_byte1: got %h want 3c", d); end
        bus_stop();
        vec_cnt++; if (rx_last !== 8'h10) begin err_cnt++; $display("FAIL rstart_rx_byte: got %h want 10", rx_last); end
        vec_cnt++; if (rxv_cnt !== 1) begin err_cnt++; $display("FAIL rstart_rx_valid_cnt: got %0d want 1", rxv_cnt); end
        vec_cnt++; if (txr_cnt !== 2) begin err_cnt++; $display("FAIL rstart_tx_req_cnt: got %0d want 2", txr_cnt); end
    endtask

    task automatic test_reset_mid_byte();
        logic ack;
        rxv_cnt = 0;
        bus_start();
        write_byte({7'd5, 1'b0}, ack);
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        tb_sda_low = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        vec_cnt++; if (sda !== 1'b1) begin err_cnt++; $display("FAIL midreset_sda: got %b want released", sda); end
        vec_cnt++; if (state !== 4'd0) begin err_cnt++; $display("FAIL midreset_state: got %0d want 0", state); end
        wait_clk(2);
        reset = 1'b0;
        scl = 1'b1;
        wait_clk(Q);
        vec_cnt++; if (rxv_cnt !== 0) begin err_cnt++; $display("FAIL midreset_rx_valid: got %0d want 0", rxv_cnt); end
        bus_start();
        write_byte({7'd5, 1'b0}, ack);
        write_byte(8'h55, ack);
        vec_cnt++; if (ack !== 1'b0) begin err_cnt++; $display("FAIL midreset_data_ack: got %b want 0", ack); end
        bus_stop();
        vec_cnt++; if (rx_last !== 8'h55) begin err_cnt++; $display("FAIL midreset_rx_byte: got %h want 55", rx_last); end
        vec_cnt++; if (rxv_cnt !== 1) begin err_cnt++; $display("FAIL midreset_rx_valid_cnt: got %0d want 1", rxv_cnt); end
    endtask

`ifdef I2C_PERIPH_GLITCH_FILTER_EN
    task automatic test_glitch();
        scl = 1'b1;
        tb_sda_low = 1'b0;
        wait_clk(Q);
        tb_sda_low = 1'b1;
        wait_clk(1);
        tb_sda_low = 1'b0;
        wait_clk(Q);
        vec_cnt++; if (state !== 4'd0) begin err_cnt++; $display("FAIL glitch_state: got %0d want 0", state); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_repeated_start();
        test_reset_mid_byte();
`ifdef I2C_PERIPH_GLITCH_FILTER_EN
        test_glitch();
`endif
        vec_cnt++; if (both_cnt !== 0) begin err_cnt++; $display("FAIL pulse_overlap: got %0d want 0", both_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_peripheral.md
# i2c_peripheral

Single-address I2C target (responder) that sits on the same bus as `i2c_controller` and answers it. It oversamples `scl`/`sda` on the system clock, detects START/STOP, matches a 7-bit address, and ACKs. In a write transfer it delivers received bytes to fabric logic; in a read transfer it shifts out bytes supplied by fabric logic. It never drives `scl`: there is no clock stretching.

## Interface
- `ADDR`, default 7'd5: 7-bit bus address this target responds to.
- `clk  input  1`: system clock; must be at least 8× the bus `scl` frequency.
- `reset  input  1`: asynchronous, active-high reset.
- `scl  input  1`: bus clock from the controller.
- `sda  inout  1`: open-drain data line. The block drives only 1'b0 or 1'bz, never 1'b1.
- `tx_byte  input  8`: next byte to send in a read transfer. Sampled when `tx_req` is high.
- `rx_byte  output  8`: last byte received in a write transfer.
- `rx_valid  output  1`: one-cycle pulse when `rx_byte` updates.
- `tx_req  output  1`: one-cycle pulse; `tx_byte` is loaded into the shifter on the same cycle.
- `busy  output  1`: high from address match until STOP or a repeated START.
- `state  output  4`: current FSM state encoding, for debug.

## Operation
- **Input conditioning.** `scl` and `sda` pass through 2-FF synchronizers. Edge detection compares the synchronized value with its previous value.
- **START.** Synchronized `sda` falls while synchronized `scl` is high, from any state. The block goes to ADDR and clears the bit counter. A repeated START behaves the same.
- **STOP.** Synchronized `sda` rises while `scl` is high, from any state. The block goes to IDLE and releases `sda`.
- **Sampling.** Data bits are sampled on the `scl` rising event, MSB first.
- **Driving.** `sda` only changes on the cycle after an `scl` falling event.
- **States:**
  - IDLE: `sda` released; waits for START.
  - ADDR: shifts 8 bits (address[6:0], then R/W).
    - On the 8th `scl` fall, if address == `ADDR`, goes to ADDR_ACK; otherwise goes to IGNORE.
  - ADDR_ACK: drives `sda` low for one `scl` period, and sets `busy`.
    - On the next `scl` fall with R/W=0, goes to RX.
    - With R/W=1, pulses `tx_req`, loads `tx_byte`, drives its MSB, and goes to TX.
  - RX: shifts 8 bits.
    - On the 8th `scl` fall: `rx_byte` ← shifter, pulse `rx_valid`, go to RX_ACK.
  - RX_ACK: drives `sda` low for one `scl` period, then returns to RX. Every received byte is ACKed.
  - TX: presents a bit after each `scl` fall. A 0 bit drives low; a 1 bit releases.
    - After the 8th bit's `scl` fall, releases `sda` and goes to TX_ACK.
  - TX_ACK: samples the controller's bit on `scl` rise.
    - ACK (0): on `scl` fall, pulses `tx_req`, reloads, and goes to TX.
    - NACK (1): goes to IGNORE.
  - IGNORE: `sda` released; waits for STOP or START.
- **Reset values.** `rx_byte` = 8'h00; `rx_valid`, `tx_req`, `busy` = 0; `sda` = z; `state` = IDLE. Bit counter and shifter are cleared.
- **Reset mid-transfer.** Bus is released immediately (asynchronously) and the current byte is lost.
- **Bit counter.** 3-bit counter; wraps 7→0 at each byte boundary. A START resets it regardless of its value.

## Timing
- Bus event recognized 3 `clk` after the pin edge (2 sync + 1 edge detect).
- `sda` drive changes 1 `clk` after the `scl` fall is recognized, i.e. 4 `clk` after the pin edge. This gives hold time relative to `scl` falling.
- `rx_valid` asserts on the cycle the 8th-bit `scl` fall is recognized.
- `tx_req` asserts on the cycle `tx_byte` is loaded, 1 `clk` before its MSB appears on `sda`.
- `rx_valid` and `tx_req` are never high simultaneously.
- START/STOP takes priority over any data/ACK action recognized on the same cycle.

## Configuration
- `I2C_PERIPH_GLITCH_FILTER_EN`.
- **Defined:** after the synchronizers, each line passes a filter that only accepts a new level after 3 consecutive identical samples. Single-`clk` glitches are rejected. All latencies in Timing increase by 2 `clk`.
- **Undefined:** no filter; latencies as stated.

## Test plan
- **Write to matching address.** Reset, then START, address 7'd5 + W, data 8'h07, STOP → ACK seen low on the 9th `scl` after the address and after the data. `rx_valid` pulses once with `rx_byte`=8'h07. `busy` falls after STOP.
- **Read transfer.** `tx_byte`=8'hA5, then START, 7'd5 + R, controller NACKs after 1 byte → `sda` bits 1,0,1,0,0,1,0,1. `tx_req` pulses once. The block is in IGNORE and then IDLE after STOP.
- **Address mismatch.** START, 7'd6 + W, 8'hFF → `sda` never driven low, no `rx_valid`, `busy` stays 0.
- **Repeated START.** START, 7'd5 + W, 8'h10, repeated START, 7'd5 + R with ACK then NACK, `tx_byte`=8'h3C → `rx_byte`=8'h10, then two bytes transmitted, `tx_req` pulses twice.
- **Reset mid-byte.** Assert `reset` after 4 data bits of a write → `sda` is z within the same cycle, `state`=IDLE, no `rx_valid`. A following full write of 8'h55 is received correctly.
- **Glitch rejection** (with `I2C_PERIPH_GLITCH_FILTER_EN`). 1-`clk` low pulse on `sda` while `scl` is high during IDLE → no START detected; `state` remains IDLE.
